// File: rtl/t03_wishbone_subordinate.sv
// Wishbone classic subordinate in front of a byte-maskable word SRAM.
// The acknowledge is delayed by a programmable number of wait states, and ACK_O/DAT_O are both registered.
module t03_wishbone_subordinate #(
  parameter logic [7:0] BASE_HI     = 8'h33,
  parameter int         DEPTH       = 256,
  parameter int         WAIT_STATES = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] ADR_I,
  input  logic [31:0] DAT_I,
  input  logic [3:0]  SEL_I,
  input  logic        WE_I,
  input  logic        STB_I,
  input  logic        CYC_I,
  output logic [31:0] DAT_O,
  output logic        ACK_O
);
  localparam int          IW = $clog2(DEPTH);
  localparam logic [3:0]  WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:2] adr_q;
  logic [31:0] dat_q;
  logic [3:0]  sel_q;
  logic        we_q;

  logic [3:0][7:0] mem [DEPTH];

  logic          req;
  logic          in_range;
  logic          access;
  logic [IW-1:0] idx;

  assign req      = CYC_I & STB_I;
  // In range only if no address bits above the word index are set within the window.
  assign in_range = (adr_q[31:24] == BASE_HI) && ((adr_q[23:2] >> IW) == '0);
  assign idx      = adr_q[IW+1:2];
  assign access   = (state == S_WAIT) && req && (cnt == 4'd0);

  // Storage has no reset. A write only lands on a live, non-reset access edge.
  always_ff @(posedge CLK) begin
    if (nRST && access && we_q && in_range) begin
      for (int k = 0; k < 4; k++) begin
        if (sel_q[k]) mem[idx][k] <= dat_q[8*k +: 8];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      adr_q <= '0;
      dat_q <= '0;
      sel_q <= '0;
      we_q  <= 1'b0;
      ACK_O <= 1'b0;
      DAT_O <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            adr_q <= ADR_I[31:2];
            dat_q <= DAT_I;
            sel_q <= SEL_I;
            we_q  <= WE_I;
            cnt   <= WS;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!req) begin
            state <= S_IDLE;
          end else if (cnt == 4'd0) begin
            state <= S_ACK;
            ACK_O <= 1'b1;
            DAT_O <= (in_range && !we_q) ? mem[idx] : 32'h0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_ACK: begin
          state <= S_IDLE;
          ACK_O <= 1'b0;
          DAT_O <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_t03_wishbone_subordinate.sv
// Directed bench: reset, round trip, byte lanes, decode, abort, and latency sweep over four wait-state settings.
module tb_t03_wishbone_subordinate;
  logic        clk = 1'b0;
  logic        nrst;
  logic [31:0] adr, wdat;
  logic [3:0]  sel;
  logic        we;
  logic [3:0]  stb, cyc, ack;
  logic [31:0] rdat [4];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Instance d has wait states 2, 0, 1, 15 for d = 0..3.
  t03_wishbone_subordinate #(.WAIT_STATES(2)) u_ws2 (
    .CLK(clk), .nRST(nrst), .ADR_I(adr), .DAT_I(wdat), .SEL_I(sel), .WE_I(we),
    .STB_I(stb[0]), .CYC_I(cyc[0]), .DAT_O(rdat[0]), .ACK_O(ack[0]));
  t03_wishbone_subordinate #(.WAIT_STATES(0)) u_ws0 (
    .CLK(clk), .nRST(nrst), .ADR_I(adr), .DAT_I(wdat), .SEL_I(sel), .WE_I(we),
    .STB_I(stb[1]), .CYC_I(cyc[1]), .DAT_O(rdat[1]), .ACK_O(ack[1]));
  t03_wishbone_subordinate #(.WAIT_STATES(1)) u_ws1 (
    .CLK(clk), .nRST(nrst), .ADR_I(adr), .DAT_I(wdat), .SEL_I(sel), .WE_I(we),
    .STB_I(stb[2]), .CYC_I(cyc[2]), .DAT_O(rdat[2]), .ACK_O(ack[2]));
  t03_wishbone_subordinate #(.WAIT_STATES(15)) u_ws15 (
    .CLK(clk), .nRST(nrst), .ADR_I(adr), .DAT_I(wdat), .SEL_I(sel), .WE_I(we),
    .STB_I(stb[3]), .CYC_I(cyc[3]), .DAT_O(rdat[3]), .ACK_O(ack[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after an edge. Returns 1 time unit after the edge that follows the ACK cycle.
  task automatic xfer(input string tag, input int d, input logic w, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] s,
                      input logic [31:0] exp_dat, input int exp_lat);
    int   lat;
    logic pre_bad;
    lat = 0;
    pre_bad = 1'b0;
    we = w; adr = a; wdat = wd; sel = s;
    stb[d] = 1'b1; cyc[d] = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (ack[d] === 1'b1) begin
        lat = k;
        break;
      end
      if (rdat[d] !== 32'h0) pre_bad = 1'b1;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_dat"}, rdat[d], exp_dat);
    chk({tag, "_pre0"}, {31'h0, pre_bad}, 32'h0);
    stb[d] = 1'b0; cyc[d] = 1'b0;
    step();
    chk({tag, "_ack_after"}, {31'h0, ack[d]}, 32'h0);
    chk({tag, "_dat_after"}, rdat[d], 32'h0);
  endtask

  // Two reads with STB held high across both transfers.
  task automatic b2b(input string tag, input int d, input int ws,
                     input logic [31:0] a0, input logic [31:0] e0,
                     input logic [31:0] a1, input logic [31:0] e1);
    int nack, t0, t1;
    nack = 0; t0 = 0; t1 = 0;
    we = 1'b0; sel = 4'hF; adr = a0;
    stb[d] = 1'b1; cyc[d] = 1'b1;
    for (int k = 1; k <= 2*ws + 12; k++) begin
      step();
      if (ack[d] === 1'b1) begin
        nack++;
        if (nack == 1) begin
          t0 = k;
          chk({tag, "_d0"}, rdat[d], e0);
          adr = a1;
        end else if (nack == 2) begin
          t1 = k;
          chk({tag, "_d1"}, rdat[d], e1);
          stb[d] = 1'b0; cyc[d] = 1'b0;
        end
      end
    end
    stb[d] = 1'b0; cyc[d] = 1'b0;
    chk({tag, "_nack"}, nack, 2);
    chk({tag, "_lat"}, t0, ws + 2);
    chk({tag, "_gap"}, t1 - t0, ws + 3);
  endtask

  task automatic no_ack_window(input string tag, input int d, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      step();
      if (ack[d] !== 1'b0) seen = 1'b1;
    end
    chk(tag, {31'h0, seen}, 32'h0);
  endtask

  initial begin
    logic rst_bad;
    nrst = 1'b0; adr = '0; wdat = '0; sel = '0; we = 1'b0;
    stb = '0; cyc = '0;
    step();
    step();

    // Reset held for 3 cycles while a write request is pending.
    rst_bad = 1'b0;
    we = 1'b1; adr = 32'h3300_0010; wdat = 32'hDEAD_BEEF; sel = 4'hF;
    stb[0] = 1'b1; cyc[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      if (ack[0] !== 1'b0 || rdat[0] !== 32'h0) rst_bad = 1'b1;
    end
    chk("reset_outputs", {31'h0, rst_bad}, 32'h0);
    nrst = 1'b1;
    xfer("rst_release", 0, 1'b1, 32'h3300_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 4);

    xfer("rt_wr", 0, 1'b1, 32'h3300_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 4);
    xfer("rt_rd", 0, 1'b0, 32'h3300_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 4);

    xfer("lane_wr", 0, 1'b1, 32'h3300_0010, 32'h1122_3344, 4'b0101, 32'h0, 4);
    xfer("lane_rd", 0, 1'b0, 32'h3300_0010, 32'h0, 4'hF, 32'hDE22_BE44, 4);

    xfer("oor_wr", 0, 1'b1, 32'h3400_0010, 32'h1234_5678, 4'hF, 32'h0, 4);
    xfer("oor_chk", 0, 1'b0, 32'h3300_0010, 32'h0, 4'hF, 32'hDE22_BE44, 4);
    xfer("oor_depth", 0, 1'b0, 32'h3300_0400, 32'h0, 4'hF, 32'h0, 4);
    xfer("oor_byteaddr", 0, 1'b0, 32'h3300_0013, 32'h0, 4'hF, 32'hDE22_BE44, 4);

    // Abort by dropping CYC_I in the first WAIT cycle.
    xfer("ab_init", 0, 1'b1, 32'h3300_0020, 32'h0BAD_F00D, 4'hF, 32'h0, 4);
    we = 1'b1; adr = 32'h3300_0020; wdat = 32'hAAAA_AAAA; sel = 4'hF;
    stb[0] = 1'b1; cyc[0] = 1'b1;
    step();
    cyc[0] = 1'b0;
    step();
    stb[0] = 1'b0;
    no_ack_window("ab_cyc_noack", 0, 8);
    xfer("ab_cyc_rd", 0, 1'b0, 32'h3300_0020, 32'h0, 4'hF, 32'h0BAD_F00D, 4);

    // Same sequence, with reset asserted in the first WAIT cycle instead.
    we = 1'b1; adr = 32'h3300_0020; wdat = 32'hAAAA_AAAA; sel = 4'hF;
    stb[0] = 1'b1; cyc[0] = 1'b1;
    step();
    nrst = 1'b0;
    step();
    nrst = 1'b1; stb[0] = 1'b0; cyc[0] = 1'b0;
    no_ack_window("ab_rst_noack", 0, 8);
    xfer("ab_rst_rd", 0, 1'b0, 32'h3300_0020, 32'h0, 4'hF, 32'h0BAD_F00D, 4);

    // Latency sweep.
    xfer("ws0_w0", 1, 1'b1, 32'h3300_0040, 32'hA0A0_0001, 4'hF, 32'h0, 2);
    xfer("ws0_w1", 1, 1'b1, 32'h3300_0044, 32'hB0B0_0001, 4'hF, 32'h0, 2);
    b2b("ws0_b2b", 1, 0, 32'h3300_0040, 32'hA0A0_0001, 32'h3300_0044, 32'hB0B0_0001);

    xfer("ws1_w0", 2, 1'b1, 32'h3300_0040, 32'hA0A0_0002, 4'hF, 32'h0, 3);
    xfer("ws1_w1", 2, 1'b1, 32'h3300_0044, 32'hB0B0_0002, 4'hF, 32'h0, 3);
    b2b("ws1_b2b", 2, 1, 32'h3300_0040, 32'hA0A0_0002, 32'h3300_0044, 32'hB0B0_0002);

    xfer("ws15_w0", 3, 1'b1, 32'h3300_0040, 32'hA0A0_000F, 4'hF, 32'h0, 17);
    xfer("ws15_w1", 3, 1'b1, 32'h3300_0044, 32'hB0B0_000F, 4'hF, 32'h0, 17);
    b2b("ws15_b2b", 3, 15, 32'h3300_0040, 32'hA0A0_000F, 32'h3300_0044, 32'hB0B0_000F);

    b2b("ws2_b2b", 0, 2, 32'h3300_0010, 32'hDE22_BE44, 32'h3300_0020, 32'h0BAD_F00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
